// File: rtl/pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// pingpong_ctrl
//
// Game sequencer for the 9-bit LED ping-pong field. The ball position lives
// in an external 9-bit shift/load register whose Q outputs are fed back on
// `q`. This block decides each cycle whether that register holds, shifts
// toward Q[8], shifts toward Q[0], clears, or loads a serve position. It also
// detects hits, misses and early presses, and it keeps the score.
//
// Player A defends the Q[0] end and player B defends the Q[8] end.
//
// Optional feature macro: PINGPONG_SPEEDUP_EN
//   Defined   : a 3-bit rally counter (saturates at 6) counts the hits in the
//               current rally. The ball step period is STEP_DIV >> (rally/2),
//               with a floor of 2 cycles.
//   Undefined : the ball step period is always STEP_DIV.
//
// Parameters:
//   STEP_DIV   clock cycles per ball step (minimum 2)
//   WIN_SCORE  points that end the game (1..15)
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   start      one-cycle pulse; begins a game from IDLE or OVER
//   btn_a      one-cycle hit pulse from player A (already debounced)
//   btn_b      one-cycle hit pulse from player B (already debounced)
//   q          Q feedback from the LED register (current ball position)
//   sl         register S_L: 1 = parallel load, 0 = shift toward Q[8]
//   s_in       register serial input; always 0
//   p_in       register parallel input
//   score_a    player A score
//   score_b    player B score
//   state      IDLE=0 SERVE=1 MOVE_UP=2 MOVE_DN=3 POINT=4 OVER=5
//   game_over  high while in OVER
// -----------------------------------------------------------------------------
module pingpong_ctrl #(
  parameter int STEP_DIV  = 12500000,
  parameter int WIN_SCORE = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic [8:0] q,
  output logic       sl,
  output logic       s_in,
  output logic [8:0] p_in,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [2:0] state,
  output logic       game_over
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SERVE   = 3'd1,
    ST_MOVE_UP = 3'd2,
    ST_MOVE_DN = 3'd3,
    ST_POINT   = 3'd4,
    ST_OVER    = 3'd5
  } state_e;

  // Register action requested for the coming clock edge.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_UP,
    ACT_DN,
    ACT_CLR,
    ACT_LOAD_A,
    ACT_LOAD_B
  } act_e;

  localparam int             CNT_W     = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [3:0]     WIN       = 4'(WIN_SCORE);

  // Server encoding: 0 = player A, 1 = player B.
  localparam logic SRV_A = 1'b0;
  localparam logic SRV_B = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       score_a_q, score_a_d;
  logic [3:0]       score_b_q, score_b_d;
  logic             server_q, server_d;

  // ---------------------------------------------------------------------------
  // Step period and tick
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] move_last;  // last count value while the ball is moving
  logic [CNT_W-1:0] cnt_last;
  logic             in_move;
  logic             tick;

`ifdef PINGPONG_SPEEDUP_EN
  logic [2:0]  rally_q, rally_d;
  logic [31:0] fast_period;

  // rally/2 is simply rally[2:1]; with rally capped at 6 the shift tops out
  // at 3, which gives the STEP_DIV/8 minimum.
  always_comb begin
    fast_period = 32'(STEP_DIV) >> rally_q[2:1];
    if (fast_period < 32'd2) begin
      fast_period = 32'd2;
    end
  end

  assign move_last = CNT_W'(fast_period - 32'd1);
`else
  assign move_last = STEP_LAST;
`endif

  assign in_move  = (state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DN);
  // POINT always waits the full STEP_DIV. The rally speed applies only to
  // ball travel.
  assign cnt_last = in_move ? move_last : STEP_LAST;
  assign tick     = (cnt_q == cnt_last);

  // ---------------------------------------------------------------------------
  // Rally event decode (shared by the next-state and output logic)
  // ---------------------------------------------------------------------------
  logic recv_btn;   // button of the player the ball is travelling toward
  logic at_end;     // ball sits on the receiver's last LED
  logic lost_ball;  // ball on the end, or q corrupt (all zero)
  logic ev_hit;
  logic ev_point;
  logic ev_step;

  // NOTE: every variable written in an always_comb gets a default before any
  // branch. A path that leaves a variable unassigned infers a latch.
  always_comb begin
    recv_btn = 1'b0;
    at_end   = 1'b0;
    case (state_q)
      ST_MOVE_UP: begin
        recv_btn = btn_b;
        at_end   = q[8];
      end
      ST_MOVE_DN: begin
        recv_btn = btn_a;
        at_end   = q[0];
      end
      default: ;
    endcase

    // A press that does not meet the ball is an early press, and so a point
    // for the opponent. A press that meets the ball wins over a tick that
    // falls on the same cycle.
    lost_ball = at_end || (q == 9'd0);
    ev_hit    = in_move && recv_btn && at_end;
    ev_point  = in_move && ((recv_btn && !at_end) || (!recv_btn && tick && lost_ball));
    ev_step   = in_move && !recv_btn && tick && !lost_ball;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples the value it had before the edge, whatever the order of
  // evaluation.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous, so it sits inside the clocked block and
    // is not in the sensitivity list.
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      score_a_q <= '0;
      score_b_q <= '0;
      server_q  <= SRV_A;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      server_q  <= server_d;
    end
  end

`ifdef PINGPONG_SPEEDUP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rally_q <= '0;
    end else begin
      rally_q <= rally_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    server_d  = server_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SERVE;
        end
      end

      ST_SERVE: begin
        // Only the server's button launches the ball.
        if (server_q == SRV_A && btn_a) begin
          state_d = ST_MOVE_UP;
        end else if (server_q == SRV_B && btn_b) begin
          state_d = ST_MOVE_DN;
        end
      end

      ST_MOVE_UP: begin
        if (ev_hit) begin
          state_d = ST_MOVE_DN;
        end else if (ev_point) begin
          // A scores. B lost the point, so B serves next.
          state_d   = ST_POINT;
          score_a_d = score_a_q + 4'd1;
          server_d  = SRV_B;
        end
      end

      ST_MOVE_DN: begin
        if (ev_hit) begin
          state_d = ST_MOVE_UP;
        end else if (ev_point) begin
          state_d   = ST_POINT;
          score_b_d = score_b_q + 4'd1;
          server_d  = SRV_A;
        end
      end

      ST_POINT: begin
        // The loser now holds the serve, so the scorer is the other player.
        if (tick) begin
          if ((server_q == SRV_B ? score_a_q : score_b_q) == WIN) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_SERVE;
          end
        end
      end

      ST_OVER: begin
        if (start) begin
          state_d   = ST_SERVE;
          score_a_d = '0;
          score_b_d = '0;
          server_d  = SRV_A;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // The step counter wraps on its tick. It restarts on any state change and
  // on a hit, so every new ball flight gets a full period.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (state_d != state_q || ev_hit) begin
      cnt_d = '0;
    end
  end

`ifdef PINGPONG_SPEEDUP_EN
  always_comb begin
    rally_d = rally_q;
    if (state_d == ST_SERVE && state_q != ST_SERVE) begin
      rally_d = '0;
    end else if (ev_hit && rally_q != 3'd6) begin
      rally_d = rally_q + 3'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Output logic: register control for the coming edge
  // ---------------------------------------------------------------------------
  act_e act;

  always_comb begin
    act = ACT_CLR;
    case (state_q)
      ST_SERVE: act = (server_q == SRV_B) ? ACT_LOAD_B : ACT_LOAD_A;
      ST_MOVE_UP,
      ST_MOVE_DN: begin
        if (ev_point) begin
          act = ACT_CLR;
        end else if (ev_step) begin
          act = (state_q == ST_MOVE_UP) ? ACT_UP : ACT_DN;
        end else begin
          act = ACT_HOLD;
        end
      end
      default: act = ACT_CLR;
    endcase

    sl   = 1'b1;
    s_in = 1'b0;
    p_in = q;
    case (act)
      ACT_HOLD:   p_in = q;
      ACT_UP:     sl   = 1'b0;
      ACT_DN:     p_in = {1'b0, q[8:1]};
      ACT_CLR:    p_in = 9'h000;
      ACT_LOAD_A: p_in = 9'h001;
      ACT_LOAD_B: p_in = 9'h100;
      default:    p_in = 9'h000;
    endcase

    // Clear the register on the same edge that resets this block.
    if (rst) begin
      sl   = 1'b1;
      p_in = 9'h000;
    end
  end

  assign state     = state_q;
  assign score_a   = score_a_q;
  assign score_b   = score_b_q;
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pingpong_ctrl
//
// Testbench for pingpong_ctrl with STEP_DIV=4 and WIN_SCORE=3. It holds a
// behavioural model of the 9-bit LED shift/load register and closes the
// q feedback loop through it.
//
// Random player behaviour is generated from a game-level reference model. The
// model tracks the ball as an LED index, the scores, the server and a phase
// timer. For every clock edge the stimulus process pushes the expected
// post-edge view onto a queue. A monitor process pops one entry after each
// rising edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_pingpong_ctrl;

  localparam int STEP_DIV  = 4;
  localparam int WIN_SCORE = 3;
  localparam int N_CYCLES  = 8000;

  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_UP    = 2;
  localparam int S_DN    = 3;
  localparam int S_POINT = 4;
  localparam int S_OVER  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       btn_a;
  logic       btn_b;
  logic [8:0] q;
  logic       sl;
  logic       s_in;
  logic [8:0] p_in;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic [2:0] state;
  logic       game_over;

  pingpong_ctrl #(
    .STEP_DIV (STEP_DIV),
    .WIN_SCORE(WIN_SCORE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .btn_a    (btn_a),
    .btn_b    (btn_b),
    .q        (q),
    .sl       (sl),
    .s_in     (s_in),
    .p_in     (p_in),
    .score_a  (score_a),
    .score_b  (score_b),
    .state    (state),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  // The LED register on the field: parallel load when sl=1, otherwise shift
  // toward Q[8] with s_in entering at Q[0].
  logic [8:0] led_q = 9'h000;
  always @(posedge clk) begin
    if (sl) led_q <= p_in;
    else    led_q <= {led_q[7:0], s_in};
  end
  assign q = led_q;

  // ---------------------------------------------------------------------------
  // Checking bookkeeping
  // ---------------------------------------------------------------------------
  int n_total  = 0;
  int n_passed = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) begin
      n_passed++;
    end else begin
      $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
               name, $time, actual, actual, expected, expected);
    end
  endtask

  typedef struct {
    int st;
    int led;
    int sa;
    int sb;
    int over;
  } exp_t;

  exp_t exp_q[$];
  bit   stim_done = 1'b0;

  // ---------------------------------------------------------------------------
  // Game-level reference model
  // ---------------------------------------------------------------------------
  int m_state  = S_IDLE;
  int m_ball   = -1;  // lit LED index, -1 when the field is dark
  int m_server = 0;   // 0 = A, 1 = B
  int m_sa     = 0;
  int m_sb     = 0;
  int m_phase  = 0;   // cycles into the current step window
  int m_rally  = 0;   // hits in this rally, capped at 6

  task automatic model_step(input bit r, input bit st, input bit a, input bit b);
    int  period;
    int  nstate;
    int  goal;
    int  winner_score;
    bit  tick;
    bit  press;
    bit  restart;
    if (r) begin
      m_state  = S_IDLE;
      m_ball   = -1;
      m_server = 0;
      m_sa     = 0;
      m_sb     = 0;
      m_phase  = 0;
      m_rally  = 0;
      return;
    end
    period = STEP_DIV;
`ifdef PINGPONG_SPEEDUP_EN
    if (m_state == S_UP || m_state == S_DN) begin
      period = STEP_DIV / (1 << (m_rally / 2));
      if (period < 2) period = 2;
    end
`endif
    tick    = (m_phase == period - 1);
    nstate  = m_state;
    restart = 1'b0;
    case (m_state)
      S_IDLE: begin
        m_ball = -1;
        if (st) nstate = S_SERVE;
      end
      S_SERVE: begin
        m_ball = (m_server == 1) ? 8 : 0;
        if (m_server == 0 && a) nstate = S_UP;
        if (m_server == 1 && b) nstate = S_DN;
      end
      S_UP, S_DN: begin
        press = (m_state == S_UP) ? b : a;
        goal  = (m_state == S_UP) ? 8 : 0;
        if (press && m_ball == goal) begin
          nstate  = (m_state == S_UP) ? S_DN : S_UP;
          restart = 1'b1;
          if (m_rally < 6) m_rally++;
        end else if (press || (tick && m_ball == goal)) begin
          if (m_state == S_UP) begin
            m_sa++;
            m_server = 1;
          end else begin
            m_sb++;
            m_server = 0;
          end
          m_ball = -1;
          nstate = S_POINT;
        end else if (tick) begin
          m_ball = m_ball + ((m_state == S_UP) ? 1 : -1);
        end
      end
      S_POINT: begin
        m_ball = -1;
        if (m_phase == STEP_DIV - 1) begin
          winner_score = (m_server == 1) ? m_sa : m_sb;
          nstate = (winner_score == WIN_SCORE) ? S_OVER : S_SERVE;
        end
      end
      default: begin  // S_OVER
        m_ball = -1;
        if (st) begin
          m_sa     = 0;
          m_sb     = 0;
          m_server = 0;
          nstate   = S_SERVE;
        end
      end
    endcase
    if (nstate == S_SERVE && m_state != S_SERVE) m_rally = 0;
    if (nstate != m_state || restart) m_phase = 0;
    else                              m_phase = tick ? 0 : m_phase + 1;
    m_state = nstate;
  endtask

  function automatic bit chance(input int one_in);
    return ($urandom_range(0, one_in - 1) == 0);
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus: random players driven from the model's view of the game
  // ---------------------------------------------------------------------------
  initial begin
    bit   r, st, a, b;
    bit   recv_at_end;
    exp_t e;
    rst   = 1'b1;
    start = 1'b0;
    btn_a = 1'b0;
    btn_b = 1'b0;
    for (int i = 0; i < N_CYCLES; i++) begin
      @(negedge clk);
      if (n_total - n_passed > 40) break;
      r  = 1'b0;
      st = 1'b0;
      a  = 1'b0;
      b  = 1'b0;
      if (i < 2) begin
        r = 1'b1;
      end else if (i == 2) begin
        st = 1'b1;
      end else begin
        case (m_state)
          S_IDLE, S_OVER: begin
            st = chance(4);
            a  = chance(8);
            b  = chance(8);
          end
          S_SERVE: begin
            st = chance(4);
            a  = (m_server == 0) ? chance(3) : chance(4);
            b  = (m_server == 1) ? chance(3) : chance(4);
          end
          S_UP, S_DN: begin
            recv_at_end = (m_state == S_UP) ? (m_ball == 8) : (m_ball == 0);
            st = chance(10);
            if (m_state == S_UP) begin
              b = recv_at_end ? chance(2) : chance(150);
              a = chance(6);
            end else begin
              a = recv_at_end ? chance(2) : chance(150);
              b = chance(6);
            end
            r = chance(400);
          end
          default: begin
            st = chance(4);
            a  = chance(4);
            b  = chance(4);
          end
        endcase
        if (chance(3000)) r = 1'b1;
      end
      rst   = r;
      start = st;
      btn_a = a;
      btn_b = b;
      model_step(r, st, a, b);
      e.st   = m_state;
      e.led  = (m_ball < 0) ? 0 : (1 << m_ball);
      e.sa   = m_sa;
      e.sb   = m_sb;
      e.over = (m_state == S_OVER) ? 1 : 0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    rst       = 1'b0;
    start     = 1'b0;
    btn_a     = 1'b0;
    btn_b     = 1'b0;
    stim_done = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",     int'(state),     e.st);
        check("q",         int'(q),         e.led);
        check("score_a",   int'(score_a),   e.sa);
        check("score_b",   int'(score_b),   e.sb);
        check("game_over", int'(game_over), e.over);
        check("s_in",      int'(s_in),      0);
      end else if (stim_done) begin
        break;
      end
      cyc++;
      if (cyc > N_CYCLES + 100) begin
        check("monitor_timeout", cyc, N_CYCLES + 100);
        break;
      end
    end
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
